// File: rtl/mem_bus_arbiter_if.sv
// Core bus (C) between the fetch/load-store arbiter and the single-port memory.
// The arbiter is the master; the memory side answers with a one-cycle
// c_ready pulse carrying c_rdata.
interface mem_bus_arbiter_if;
    logic        c_valid;
    logic        c_write;
    logic [63:0] c_addr;
    logic [63:0] c_wdata;
    logic [7:0]  c_strobe;
    logic [2:0]  c_size;
    logic        c_ready;
    logic [63:0] c_rdata;

    modport master (
        output c_valid, c_write, c_addr, c_wdata, c_strobe, c_size,
        input  c_ready, c_rdata
    );

    modport slave (
        input  c_valid, c_write, c_addr, c_wdata, c_strobe, c_size,
        output c_ready, c_rdata
    );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Single-port memory arbiter between instruction fetch (I) and load/store (D).
// D has priority, but after MAX_D_STREAK consecutive D grants while a fetch is
// waiting, the fetch is granted. A redirect (flush) discards the response of an
// in-flight fetch; the bus beat itself always completes.
// Optional build macro ARB_PERF_CNT_EN adds a saturating count of the cycles a
// fetch spends waiting; without it i_wait_cycles is tied to zero.
module mem_bus_arbiter #(
    parameter int unsigned MAX_D_STREAK = 4
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              i_req,
    input  logic [63:0]       i_addr,
    output logic              i_ready,
    output logic [63:0]       i_rdata,

    input  logic              d_req,
    input  logic              d_write,
    input  logic [63:0]       d_addr,
    input  logic [63:0]       d_wdata,
    input  logic [7:0]        d_strobe,
    input  logic [2:0]        d_size,
    output logic              d_ready,
    output logic [63:0]       d_rdata,

    input  logic              flush,

    mem_bus_arbiter_if.master c_bus,

    output logic [31:0]       i_wait_cycles
);

    typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D, RESP} state_t;

    localparam logic [3:0] STREAK_MAX = 4'(MAX_D_STREAK);

    state_t      state_q,    state_d;
    logic        c_valid_q,  c_valid_d;
    logic        c_write_q,  c_write_d;
    logic [63:0] c_addr_q,   c_addr_d;
    logic [63:0] c_wdata_q,  c_wdata_d;
    logic [7:0]  c_strobe_q, c_strobe_d;
    logic [2:0]  c_size_q,   c_size_d;
    logic        i_ready_q,  i_ready_d;
    logic        d_ready_q,  d_ready_d;
    logic [63:0] i_rdata_q,  i_rdata_d;
    logic [63:0] d_rdata_q,  d_rdata_d;
    logic [3:0]  streak_q,   streak_d;
    logic        discard_q,  discard_d;

    // Arbitration, bus launch and response capture for the next cycle.
    always_comb begin
        // NOTE: every _d starts as its _q so paths that do not assign it hold
        // state instead of inferring a latch.
        state_d    = state_q;
        c_valid_d  = c_valid_q;
        c_write_d  = c_write_q;
        c_addr_d   = c_addr_q;
        c_wdata_d  = c_wdata_q;
        c_strobe_d = c_strobe_q;
        c_size_d   = c_size_q;
        i_rdata_d  = i_rdata_q;
        d_rdata_d  = d_rdata_q;
        streak_d   = streak_q;
        discard_d  = discard_q;
        i_ready_d  = 1'b0;
        d_ready_d  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (d_req && (!i_req || streak_q < STREAK_MAX)) begin
                    state_d    = BUSY_D;
                    c_valid_d  = 1'b1;
                    c_write_d  = d_write;
                    c_addr_d   = d_addr;
                    c_wdata_d  = d_wdata;
                    c_strobe_d = d_strobe;
                    c_size_d   = d_size;
                    // Count D wins only while a fetch is actually waiting.
                    if (i_req) begin
                        streak_d = (streak_q < STREAK_MAX) ? streak_q + 4'd1 : streak_q;
                    end else begin
                        streak_d = 4'd0;
                    end
                end else if (i_req) begin
                    state_d    = BUSY_I;
                    c_valid_d  = 1'b1;
                    c_write_d  = 1'b0;
                    c_addr_d   = i_addr;
                    c_wdata_d  = 64'd0;
                    c_strobe_d = 8'hFF;
                    c_size_d   = 3'b011;
                    streak_d   = 4'd0;
                    discard_d  = flush;
                end
            end
            BUSY_I: begin
                if (flush) begin
                    discard_d = 1'b1;
                end
                if (c_bus.c_ready) begin
                    state_d   = RESP;
                    c_valid_d = 1'b0;
                    // A redirect arriving with the response still kills it.
                    if (!(discard_q || flush)) begin
                        i_rdata_d = c_bus.c_rdata;
                        i_ready_d = 1'b1;
                    end
                end
            end
            BUSY_D: begin
                if (c_bus.c_ready) begin
                    state_d   = RESP;
                    c_valid_d = 1'b0;
                    d_rdata_d = c_bus.c_rdata;
                    d_ready_d = 1'b1;
                end
            end
            RESP: begin
                // Ready is visible during this cycle; the requester refreshes
                // or drops its request before IDLE arbitrates again.
                state_d   = IDLE;
                discard_d = 1'b0;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and registered outputs; rst clears everything, dropping any beat.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            c_valid_q  <= 1'b0;
            c_write_q  <= 1'b0;
            c_addr_q   <= 64'd0;
            c_wdata_q  <= 64'd0;
            c_strobe_q <= 8'd0;
            c_size_q   <= 3'd0;
            i_ready_q  <= 1'b0;
            d_ready_q  <= 1'b0;
            i_rdata_q  <= 64'd0;
            d_rdata_q  <= 64'd0;
            streak_q   <= 4'd0;
            discard_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the values
            // from before this edge, independent of statement order.
            state_q    <= state_d;
            c_valid_q  <= c_valid_d;
            c_write_q  <= c_write_d;
            c_addr_q   <= c_addr_d;
            c_wdata_q  <= c_wdata_d;
            c_strobe_q <= c_strobe_d;
            c_size_q   <= c_size_d;
            i_ready_q  <= i_ready_d;
            d_ready_q  <= d_ready_d;
            i_rdata_q  <= i_rdata_d;
            d_rdata_q  <= d_rdata_d;
            streak_q   <= streak_d;
            discard_q  <= discard_d;
        end
    end

    assign c_bus.c_valid  = c_valid_q;
    assign c_bus.c_write  = c_write_q;
    assign c_bus.c_addr   = c_addr_q;
    assign c_bus.c_wdata  = c_wdata_q;
    assign c_bus.c_strobe = c_strobe_q;
    assign c_bus.c_size   = c_size_q;
    assign i_ready        = i_ready_q;
    assign d_ready        = d_ready_q;
    assign i_rdata        = i_rdata_q;
    assign d_rdata        = d_rdata_q;

`ifdef ARB_PERF_CNT_EN
    logic [31:0] i_wait_cycles_q, i_wait_cycles_d;

    // Saturating count of cycles with a fetch pending but not yet answered.
    always_comb begin
        i_wait_cycles_d = i_wait_cycles_q;
        if (i_req && !i_ready_q && i_wait_cycles_q != 32'hFFFF_FFFF) begin
            i_wait_cycles_d = i_wait_cycles_q + 32'd1;
        end
    end

    // Perf counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            i_wait_cycles_q <= 32'd0;
        end else begin
            i_wait_cycles_q <= i_wait_cycles_d;
        end
    end

    assign i_wait_cycles = i_wait_cycles_q;
`else
    assign i_wait_cycles = 32'd0;
`endif

endmodule
